// File: rtl/alu_seq.sv
// Registered, handshaked ALU. Opcodes 0-6 complete in one cycle; opcode 7 is a
// fixed-latency (WIDTH cycles) shift-add multiply returning the low WIDTH bits.
module alu_seq #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_n,
  input  logic [WIDTH-1:0] in_m,
  input  logic [2:0]       opc,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_f,
  output logic             zer,
  output logic             neg,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    MUL
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] mcand, mcand_nxt;
  logic [WIDTH-1:0] mplier, mplier_nxt;
  logic [WIDTH-1:0] acc, acc_nxt;
  logic [CNT_W-1:0] count, count_nxt;
  logic [WIDTH-1:0] f_nxt;
  logic             valid_nxt, cout_nxt, ovf_nxt, busy_nxt;

  logic [WIDTH-1:0] alu_f;
  logic             alu_cout, alu_ovf;
  logic [WIDTH:0]   sum0;
  logic [WIDTH+1:0] tri_m;
  logic [WIDTH-1:0] acc_step;
  logic             accept;

  assign in_ready = (state == IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  // Widened sums so carry / signed overflow fall out of the extra bits.
  assign sum0     = {1'b0, in_n} + {1'b0, in_m} + (WIDTH+1)'(cin);
  assign tri_m    = {{2{in_m[WIDTH-1]}}, in_m} + {in_m[WIDTH-1], in_m, 1'b0};
  assign acc_step = mplier[0] ? (acc + mcand) : acc;

  // Single-cycle opcodes.
  always_comb begin
    alu_f    = '0;
    alu_cout = 1'b0;
    alu_ovf  = 1'b0;
    case (opc)
      3'd0: begin
        alu_f    = sum0[WIDTH-1:0];
        alu_cout = sum0[WIDTH];
        alu_ovf  = (in_n[WIDTH-1] == in_m[WIDTH-1]) && (sum0[WIDTH-1] != in_n[WIDTH-1]);
      end
      3'd1: alu_f = in_m + {in_n[WIDTH-1], in_n[WIDTH-1:1]};
      3'd2: alu_f = ($signed(in_n) > $signed(in_m)) ? in_n : in_m;
      3'd3: begin
        alu_f   = tri_m[WIDTH-1:0];
        // 3*M fits in WIDTH+2 signed bits; it fits WIDTH iff the top three agree.
        alu_ovf = (tri_m[WIDTH+1:WIDTH-1] != {3{tri_m[WIDTH-1]}});
      end
      3'd4: alu_f = in_n & in_m;
      3'd5: alu_f = in_n | in_m;
      3'd6: alu_f = ~in_m;
      default: alu_f = '0;
    endcase
  end

  // Next-state and datapath updates.
  always_comb begin
    state_nxt  = state;
    mcand_nxt  = mcand;
    mplier_nxt = mplier;
    acc_nxt    = acc;
    count_nxt  = count;
    f_nxt      = out_f;
    cout_nxt   = cout;
    ovf_nxt    = ovf;
    busy_nxt   = busy;
    valid_nxt  = out_valid && !out_ready;
    case (state)
      IDLE: begin
        if (accept) begin
          if (opc == 3'd7) begin
            state_nxt  = MUL;
            mcand_nxt  = in_n;
            mplier_nxt = in_m;
            acc_nxt    = '0;
            count_nxt  = '0;
            busy_nxt   = 1'b1;
          end else begin
            f_nxt     = alu_f;
            cout_nxt  = alu_cout;
            ovf_nxt   = alu_ovf;
            valid_nxt = 1'b1;
          end
        end
      end
      MUL: begin
        acc_nxt    = acc_step;
        mcand_nxt  = mcand << 1;
        mplier_nxt = mplier >> 1;
        count_nxt  = count + CNT_W'(1);
        if (count == LAST_STEP) begin
          state_nxt = IDLE;
          busy_nxt  = 1'b0;
          f_nxt     = acc_step;
          cout_nxt  = 1'b0;
          ovf_nxt   = 1'b0;
          valid_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      count     <= '0;
      out_f     <= '0;
      out_valid <= 1'b0;
      zer       <= 1'b0;
      neg       <= 1'b0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      mcand     <= mcand_nxt;
      mplier    <= mplier_nxt;
      acc       <= acc_nxt;
      count     <= count_nxt;
      out_f     <= f_nxt;
      out_valid <= valid_nxt;
      zer       <= (f_nxt == '0);
      neg       <= f_nxt[WIDTH-1];
      cout      <= cout_nxt;
      ovf       <= ovf_nxt;
      busy      <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq (WIDTH=16): directed scenarios plus random traffic, all
// results checked in order against an arithmetic reference model.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_n;
  logic [15:0] in_m;
  logic [2:0]  opc;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_f;
  logic        zer, neg, cout, ovf, busy;

  typedef struct packed {
    logic [15:0] f;
    logic        co;
    logic        ov;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   rdy_mode = 1;  // 0: random, 1: always ready, 2: stalled

  alu_seq #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_n(in_n), .in_m(in_m), .opc(opc), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready), .out_f(out_f),
    .zer(zer), .neg(neg), .cout(cout), .ovf(ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain integer arithmetic on sign/zero-extended operands.
  function automatic exp_t model(input logic [2:0] op, input logic [15:0] n,
                                 input logic [15:0] m, input logic c);
    exp_t   e;
    longint sn, sm, un, um, t;
    sn = $signed(n);
    sm = $signed(m);
    un = longint'(n);
    um = longint'(m);
    e  = '0;
    case (op)
      3'd0: begin
        t    = un + um + longint'(c);
        e.f  = t[15:0];
        e.co = (t > 65535);
        t    = sn + sm + longint'(c);
        e.ov = (t > 32767) || (t < -32768);
      end
      3'd1: begin t = sm + (sn >>> 1); e.f = t[15:0]; end
      3'd2: e.f = (sn > sm) ? n : m;
      3'd3: begin
        t    = 3 * sm;
        e.f  = t[15:0];
        e.ov = (t > 32767) || (t < -32768);
      end
      3'd4: e.f = n & m;
      3'd5: e.f = n | m;
      3'd6: e.f = ~m;
      default: begin t = un * um; e.f = t[15:0]; end
    endcase
    return e;
  endfunction

  // Monitor: chooses out_ready for the coming edge and scores every transfer.
  initial begin
    exp_t e;
    out_ready = 1'b0;
    forever begin
      @(negedge clk);
      case (rdy_mode)
        0:       out_ready = ($urandom_range(0, 3) != 0);
        1:       out_ready = 1'b1;
        default: out_ready = 1'b0;
      endcase
      if (!rst && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_output: got out_f=0x%0h expected no result", out_f);
        end else begin
          e = sb.pop_front();
          chk("out_f", 32'(out_f), 32'(e.f));
          chk("zer", 32'(zer), 32'(e.f == 16'h0));
          chk("neg", 32'(neg), 32'(e.f[15]));
          chk("cout", 32'(cout), 32'(e.co));
          chk("ovf", 32'(ovf), 32'(e.ov));
        end
      end
    end
  end

  task automatic issue(input logic [2:0] op, input logic [15:0] n, input logic [15:0] m,
                       input logic c, output int waits);
    waits = 0;
    @(negedge clk);
    in_valid = 1'b1;
    opc = op; in_n = n; in_m = m; cin = c;
    #1;
    while (!in_ready && waits < 200) begin
      @(negedge clk);
      #1;
      waits++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout: got in_ready=0 for %0d cycles expected acceptance", waits);
      in_valid = 1'b0;
      return;
    end
    sb.push_back(model(op, n, m, c));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((sb.size() != 0 || out_valid || busy) && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (t >= 500) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending results expected 0", sb.size());
    end
  endtask

  // Called right after a multiply is accepted; counts edges until the result.
  task automatic mul_latency(input string name);
    int cnt = 0;
    chk({name, "_busy"}, 32'(busy), 32'd1);
    chk({name, "_in_ready"}, 32'(in_ready), 32'd0);
    while (cnt < 40) begin
      @(negedge clk);
      if (out_valid) break;
      cnt++;
    end
    chk({name, "_latency"}, 32'(cnt), 32'd16);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w;
    logic [2:0] op;
    rst = 1'b1; in_valid = 1'b0; in_n = '0; in_m = '0; opc = '0; cin = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_f", 32'(out_f), 32'd0);
    chk("rst_flags", {27'd0, zer, neg, cout, ovf, busy}, 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Signed overflow into the sign bit, then carry-out wrap and all-zero result.
    issue(3'd0, 16'h7FFF, 16'h0001, 1'b0, w);
    @(negedge clk);
    chk("t1_latency", 32'(out_valid), 32'd1);
    issue(3'd0, 16'hFFFF, 16'h0001, 1'b1, w);
    issue(3'd6, 16'h0000, 16'hFFFF, 1'b0, w);

    // Multiply latency is fixed, including a zero operand.
    wait_drain();
    issue(3'd7, 16'hFFFD, 16'h0007, 1'b0, w);
    mul_latency("t3_mul");
    wait_drain();
    issue(3'd7, 16'h0000, 16'h1234, 1'b0, w);
    mul_latency("t3_mul_zero");

    // Backpressure: second op stalls while the first result is held.
    wait_drain();
    rdy_mode = 2;
    issue(3'd4, 16'hA5A5, 16'h0FF0, 1'b0, w);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1; opc = 3'd5; in_n = 16'hA5A5; in_m = 16'h0FF0;
      #1;
      chk("t4_in_ready", 32'(in_ready), 32'd0);
      chk("t4_hold_valid", 32'(out_valid), 32'd1);
      chk("t4_hold_f", 32'(out_f), 32'(model(3'd4, 16'hA5A5, 16'h0FF0, 1'b0).f));
    end
    rdy_mode = 1;
    issue(3'd5, 16'hA5A5, 16'h0FF0, 1'b0, w);

    // Back-to-back max operations at full throughput.
    wait_drain();
    issue(3'd2, 16'hFFFB, 16'h0003, 1'b0, w);
    chk("t5_waits0", 32'(w), 32'd0);
    issue(3'd2, 16'h0004, 16'hFFF7, 1'b0, w);
    chk("t5_waits1", 32'(w), 32'd0);
    issue(3'd2, 16'h0000, 16'h0000, 1'b0, w);
    chk("t5_waits2", 32'(w), 32'd0);

    // Reset in the middle of a multiply discards it.
    wait_drain();
    issue(3'd7, 16'h1234, 16'h0056, 1'b0, w);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_out_valid", 32'(out_valid), 32'd0);
    void'(sb.pop_back());
    issue(3'd3, 16'h0000, 16'h0005, 1'b0, w);

    // Random traffic with random backpressure.
    rdy_mode = 0;
    for (int i = 0; i < 300; i++) begin
      op = ($urandom_range(0, 9) == 0) ? 3'd7 : 3'($urandom_range(0, 6));
      issue(op, 16'($urandom), 16'($urandom), 1'($urandom), w);
      if ($urandom_range(0, 7) == 0) @(negedge clk);
    end

    wait_drain();
    rdy_mode = 1;
    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
